// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the fetch/data memory port arbiter
package mem_arb_pkg;

  localparam int unsigned MEM_AWIDTH = 32;
  localparam int unsigned MEM_DWIDTH = 32;

  typedef enum logic {
    REQ_IMEM = 1'b0,
    REQ_DMEM = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [MEM_AWIDTH-1:0]   addr;
    logic [MEM_DWIDTH-1:0]   wdata;
    logic [MEM_DWIDTH/8-1:0] wstrb;
    logic                    we;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DWIDTH-1:0] data;
    logic                  err;
  } mem_rsp_t;

endpackage

// File: rtl/mem_arb_rsp_slot.sv
// rtl/mem_arb_rsp_slot.sv - one-entry registered response buffer
// Loading while draining keeps the slot full with the new response.
module mem_arb_rsp_slot #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              err_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              err_o,
  output logic              drain_o
);

  logic              full_q, full_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              err_q, err_d;

  assign drain_o = full_q & ready_i;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    err_d  = err_q;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
      err_d  = err_i;
    end else if (drain_o) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign valid_o = full_q;
  assign data_o  = data_q;
  assign err_o   = err_q;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for the unified memory port
// MEM_ARBITER_ROUND_ROBIN_EN: alternate grants on contention instead of data priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [AWIDTH-1:0]   i_addr,
  output logic                i_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DWIDTH-1:0]   i_rsp_data,
  output logic                i_rsp_err,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [AWIDTH-1:0]   d_addr,
  input  logic                d_we,
  input  logic [DWIDTH-1:0]   d_wdata,
  input  logic [DWIDTH/8-1:0] d_wstrb,
  output logic                d_rsp_valid,
  input  logic                d_rsp_ready,
  output logic [DWIDTH-1:0]   d_rsp_data,
  output logic                d_rsp_err,
  output logic [AWIDTH-1:0]   mem_addr_o,
  output logic [DWIDTH-1:0]   mem_data_o,
  output logic [DWIDTH/8-1:0] mem_strb_o,
  output logic                mem_read_en_o,
  output logic                mem_write_en_o,
  input  logic [DWIDTH-1:0]   mem_data_i,
  input  logic                mem_vld_i
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be >= 1");
  end

  logic i_drain, d_drain, i_elig, d_elig, grant_i, grant_d;

  // A requester may be granted into a slot that is being emptied this same cycle.
  assign i_elig = i_req_valid & (~i_rsp_valid | i_drain);
  assign d_elig = d_req_valid & (~d_rsp_valid | d_drain);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  req_id_e last_q, last_d;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst) begin
      if (i_elig && d_elig) begin
        grant_d = (last_q == REQ_IMEM);
        grant_i = ~grant_d;
      end else begin
        grant_i = i_elig;
        grant_d = d_elig;
      end
    end
    last_d = last_q;
    if (grant_i)      last_d = REQ_IMEM;
    else if (grant_d) last_d = REQ_DMEM;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= REQ_IMEM;
    else     last_q <= last_d;
  end
`else
  localparam int            SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] streak_q, streak_d;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst) begin
      if (i_elig && d_elig) begin
        grant_d = (streak_q != LIMIT);
        grant_i = ~grant_d;
      end else begin
        grant_i = i_elig;
        grant_d = d_elig;
      end
    end
    // Streak counts only data wins that actually held off a waiting fetch.
    streak_d = streak_q;
    if (grant_i || !i_req_valid)
      streak_d = '0;
    else if (grant_d && i_elig && streak_q != LIMIT)
      streak_d = streak_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
  end
`endif

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  always_comb begin
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_strb_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    if (grant_i) begin
      mem_addr_o    = i_addr;
      mem_read_en_o = 1'b1;
    end else if (grant_d) begin
      mem_addr_o     = d_addr;
      mem_data_o     = d_wdata;
      mem_strb_o     = d_wstrb;
      mem_read_en_o  = ~d_we;
      mem_write_en_o = d_we;
    end
  end

  mem_arb_rsp_slot #(.DWIDTH(DWIDTH)) u_i_slot (
    .clk     (clk),
    .rst     (rst),
    .load_i  (grant_i),
    .data_i  (mem_data_i),
    .err_i   (~mem_vld_i),
    .ready_i (i_rsp_ready),
    .valid_o (i_rsp_valid),
    .data_o  (i_rsp_data),
    .err_o   (i_rsp_err),
    .drain_o (i_drain)
  );

  // Store acknowledgements carry no data and never flag an error.
  mem_arb_rsp_slot #(.DWIDTH(DWIDTH)) u_d_slot (
    .clk     (clk),
    .rst     (rst),
    .load_i  (grant_d),
    .data_i  (d_we ? '0 : mem_data_i),
    .err_i   (~d_we & ~mem_vld_i),
    .ready_i (d_rsp_ready),
    .valid_o (d_rsp_valid),
    .data_o  (d_rsp_data),
    .err_o   (d_rsp_err),
    .drain_o (d_drain)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int          SL   = 4;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] OOB  = 32'h7FFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_rsp_err;
  logic [31:0] i_addr, i_rsp_data;
  logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
  logic [31:0] d_addr, d_wdata, d_rsp_data;
  logic [3:0]  d_wstrb, mem_strb_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic        mem_read_en_o, mem_write_en_o, mem_vld_i;

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr), .d_we(d_we),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_strb_o(mem_strb_o),
    .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
    .mem_data_i(mem_data_i), .mem_vld_i(mem_vld_i)
  );

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd1024);
  endfunction

  function automatic logic [31:0] init_word(input int k);
    return 32'hC0DE_0000 | 32'(k);
  endfunction

  // Memory instance stand-in: combinational read, strobed write at posedge.
  logic [31:0] env_mem [256];
  logic        mem_init;
  assign mem_vld_i  = mem_read_en_o && in_range(mem_addr_o);
  assign mem_data_i = mem_vld_i ? env_mem[mem_addr_o[9:2]] : 32'h0;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) env_mem[k] <= init_word(k);
    end else if (mem_write_en_o && in_range(mem_addr_o)) begin
      for (int b = 0; b < 4; b++)
        if (mem_strb_o[b]) env_mem[mem_addr_o[9:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
    end
  end

  int checks, failures;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: shadow memory plus what each response slot should hold.
  logic [31:0] ref_mem [256];
  logic        m_if, m_df, m_ie, m_de;
  logic [31:0] m_id, m_dd;
  int          m_streak;
  logic        e_gi, e_gd;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return in_range(a) ? ref_mem[a[9:2]] : 32'h0;
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    if (in_range(a))
      for (int b = 0; b < 4; b++)
        if (ws[b]) ref_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic step(input logic r, input logic iv, input logic [31:0] ia, input logic ir,
                      input logic dv, input logic [31:0] da, input logic dwe,
                      input logic [31:0] dwd, input logic [3:0] dws, input logic dr);
    logic ie, de;
    @(negedge clk);
    rst = r; i_req_valid = iv; i_addr = ia; i_rsp_ready = ir;
    d_req_valid = dv; d_addr = da; d_we = dwe; d_wdata = dwd; d_wstrb = dws; d_rsp_ready = dr;
    #1;
    ie = iv && (!m_if || ir);
    de = dv && (!m_df || dr);
    e_gi = 1'b0;
    e_gd = 1'b0;
    if (!r) begin
      if (ie && de) begin
        e_gd = (m_streak < SL);
        e_gi = !e_gd;
      end else begin
        e_gi = ie;
        e_gd = de;
      end
    end
    chk1("i_req_ready", i_req_ready, e_gi);
    chk1("d_req_ready", d_req_ready, e_gd);
    chk1("i_rsp_valid", i_rsp_valid, m_if);
    chk1("d_rsp_valid", d_rsp_valid, m_df);
    if (m_if) begin
      chk32("i_rsp_data", i_rsp_data, m_id);
      chk1("i_rsp_err", i_rsp_err, m_ie);
    end
    if (m_df) begin
      chk32("d_rsp_data", d_rsp_data, m_dd);
      chk1("d_rsp_err", d_rsp_err, m_de);
    end
    chk1("mem_read_en", mem_read_en_o, e_gi || (e_gd && !dwe));
    chk1("mem_write_en", mem_write_en_o, e_gd && dwe);
    chk32("mem_addr", mem_addr_o, e_gi ? ia : (e_gd ? da : 32'h0));
    chk32("mem_strb", 32'(mem_strb_o), e_gd ? 32'(dws) : 32'h0);
    if (e_gd) chk32("mem_data", mem_data_o, dwd);
    if (r) begin
      m_if = 1'b0; m_df = 1'b0; m_streak = 0;
    end else begin
      if (e_gi) begin
        m_if = 1'b1; m_id = ref_rd(ia); m_ie = !in_range(ia);
      end else if (m_if && ir) m_if = 1'b0;
      if (e_gd) begin
        m_df = 1'b1;
        if (dwe) begin
          m_dd = 32'h0; m_de = 1'b0; ref_wr(da, dwd, dws);
        end else begin
          m_dd = ref_rd(da); m_de = !in_range(da);
        end
      end else if (m_df && dr) m_df = 1'b0;
      if (e_gi || !iv) m_streak = 0;
      else if (e_gd && ie) m_streak = (m_streak + 1 > SL) ? SL : m_streak + 1;
    end
  endtask

  typedef struct {
    logic iv; logic [31:0] ia; logic ir;
    logic dv; logic [31:0] da; logic dwe; logic [31:0] dwd; logic [3:0] dws; logic dr;
    logic x_irdy; logic x_drdy; logic x_irv; logic [31:0] x_ird;
    logic x_drv; logic [31:0] x_drd; logic x_derr;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [31:0] ia, input logic ir,
                              input logic dv, input logic [31:0] da, input logic dwe,
                              input logic [31:0] dwd, input logic [3:0] dws, input logic dr,
                              input logic x_irdy, input logic x_drdy, input logic x_irv,
                              input logic [31:0] x_ird, input logic x_drv,
                              input logic [31:0] x_drd, input logic x_derr);
    vec_t v;
    v.iv = iv; v.ia = ia; v.ir = ir; v.dv = dv; v.da = da; v.dwe = dwe;
    v.dwd = dwd; v.dws = dws; v.dr = dr;
    v.x_irdy = x_irdy; v.x_drdy = x_drdy; v.x_irv = x_irv; v.x_ird = x_ird;
    v.x_drv = x_drv; v.x_drd = x_drd; v.x_derr = x_derr;
    return v;
  endfunction

  function automatic logic [31:0] rand_in();
    return BASE + ($urandom_range(0, 255) << 2);
  endfunction

  vec_t tbl [12];
  int   run, max_run;
  logic ip_v, dp_v, dp_we;
  logic [31:0] ip_a, dp_a, dp_wd;
  logic [3:0]  dp_ws;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; mem_init = 1'b1;
    i_req_valid = 0; i_addr = 0; i_rsp_ready = 0;
    d_req_valid = 0; d_addr = 0; d_we = 0; d_wdata = 0; d_wstrb = 0; d_rsp_ready = 0;
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    m_if = 0; m_df = 0; m_ie = 0; m_de = 0; m_id = 0; m_dd = 0; m_streak = 0;

    // fetch stream, store/fetch merge, OOB load, data back-pressure
    tbl[0]  = mk(1, 32'h0100_0000, 1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 32'h0100_0004, 1, 0, 0, 0, 0, 0, 1,  1, 0, 1, 32'hC0DE_0000, 0, 0, 0);
    tbl[2]  = mk(1, 32'h0100_0008, 1, 0, 0, 0, 0, 0, 1,  1, 0, 1, 32'hC0DE_0001, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 1, 32'h0100_0010, 1, 32'hDEAD_BEEF, 4'b0011, 1,
                 0, 1, 1, 32'hC0DE_0002, 0, 0, 0);
    tbl[4]  = mk(1, 32'h0100_0010, 1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 1, 32'h0, 0);
    tbl[5]  = mk(0, 0, 1, 1, OOB, 0, 0, 0, 1,  0, 1, 1, 32'hC0DE_BEEF, 0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 32'h0, 1);
    tbl[7]  = mk(1, 32'h0100_0004, 1, 1, 32'h0100_0000, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 32'h0100_0004, 1, 1, 32'h0100_0004, 0, 0, 0, 0,
                 1, 0, 0, 0, 1, 32'hC0DE_0000, 0);
    tbl[9]  = mk(1, 32'h0100_0008, 1, 1, 32'h0100_0004, 0, 0, 0, 0,
                 1, 0, 1, 32'hC0DE_0001, 1, 32'hC0DE_0000, 0);
    tbl[10] = mk(1, 32'h0100_000C, 1, 1, 32'h0100_0004, 0, 0, 0, 1,
                 0, 1, 1, 32'hC0DE_0002, 1, 32'hC0DE_0000, 0);
    tbl[11] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 32'hC0DE_0001, 0);

    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_init = 1'b0;
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    chk1("reset_i_rsp_valid", i_rsp_valid, 1'b0);
    chk1("reset_d_rsp_valid", d_rsp_valid, 1'b0);
    chk32("reset_d_rsp_data", d_rsp_data, 32'h0);

    for (int n = 0; n < 12; n++) begin
      step(0, tbl[n].iv, tbl[n].ia, tbl[n].ir, tbl[n].dv, tbl[n].da, tbl[n].dwe,
           tbl[n].dwd, tbl[n].dws, tbl[n].dr);
      chk1($sformatf("vec%0d_i_req_ready", n), i_req_ready, tbl[n].x_irdy);
      chk1($sformatf("vec%0d_d_req_ready", n), d_req_ready, tbl[n].x_drdy);
      chk1($sformatf("vec%0d_i_rsp_valid", n), i_rsp_valid, tbl[n].x_irv);
      chk1($sformatf("vec%0d_d_rsp_valid", n), d_rsp_valid, tbl[n].x_drv);
      if (tbl[n].x_irv) chk32($sformatf("vec%0d_i_rsp_data", n), i_rsp_data, tbl[n].x_ird);
      if (tbl[n].x_drv) begin
        chk32($sformatf("vec%0d_d_rsp_data", n), d_rsp_data, tbl[n].x_drd);
        chk1($sformatf("vec%0d_d_rsp_err", n), d_rsp_err, tbl[n].x_derr);
      end
    end

    // Continuous contention: data wins SL times, then fetch once.
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    run = 0; max_run = 0;
    for (int k = 0; k < 15; k++) begin
      step(0, 1, rand_in(), 1, 1, rand_in(), 0, 32'h0, 4'h0, 1);
      chk1("contention_grant_d", d_req_ready, (k % 5) != 4);
      if (d_req_ready) run++; else run = 0;
      if (run > max_run) max_run = run;
    end
    chk1("starve_bound", max_run <= SL, 1'b1);

    // Reset with a data response pending, after a partial streak.
    repeat (3) step(0, 1, rand_in(), 1, 1, rand_in(), 0, 32'h0, 4'h0, 1);
    step(1, 1, rand_in(), 1, 1, rand_in(), 0, 32'h0, 4'h0, 0);
    chk1("rst_pending_d_rsp_valid", d_rsp_valid, 1'b1);
    chk1("rst_i_req_ready", i_req_ready, 1'b0);
    chk1("rst_d_req_ready", d_req_ready, 1'b0);
    chk1("rst_mem_read_en", mem_read_en_o, 1'b0);
    chk1("rst_mem_write_en", mem_write_en_o, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, rand_in(), 1, 1, rand_in(), 0, 32'h0, 4'h0, 1);
      if (k == 0) begin
        chk1("post_rst_i_rsp_valid", i_rsp_valid, 1'b0);
        chk1("post_rst_d_rsp_valid", d_rsp_valid, 1'b0);
      end
      chk1("post_rst_grant_d", d_req_ready, k != 4);
    end

    // Randomized traffic; requests are held until the model predicts acceptance.
    ip_v = 0; dp_v = 0; ip_a = 0; dp_a = 0; dp_we = 0; dp_wd = 0; dp_ws = 0;
    for (int c = 0; c < 600; c++) begin
      if (!ip_v && ($urandom_range(0, 3) != 0)) begin
        ip_v = 1;
        ip_a = ($urandom_range(0, 7) == 0) ? OOB : rand_in();
      end
      if (!dp_v && ($urandom_range(0, 3) != 0)) begin
        dp_v  = 1;
        dp_a  = ($urandom_range(0, 7) == 0) ? OOB : rand_in();
        dp_we = 1'($urandom_range(0, 1));
        dp_wd = $urandom;
        dp_ws = 4'($urandom_range(0, 15));
      end
      step(($urandom_range(0, 63) == 0), ip_v, ip_a, ($urandom_range(0, 3) != 0),
           dp_v, dp_a, dp_we, dp_wd, dp_ws, ($urandom_range(0, 3) != 0));
      if (e_gi) ip_v = 0;
      if (e_gd) dp_v = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
